conv_window_generator: RTL



---
 rtl/conv_window_generator.sv | 105 ++++++++++
 1 files changed

// File: rtl/conv_window_generator.sv
// Streaming 3x3 window former.
// Pixels arrive one per cycle in raster order. Two line buffers hold the two
// previous rows, so each accepted pixel supplies one new window column.
// A window is flagged only where the whole 3x3 kernel lies inside the image.
module conv_window_generator #(
    parameter int PIX_WIDTH  = 16,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIX_WIDTH-1:0]   pix_in,
    input  logic                   pix_valid,
    output logic [9*PIX_WIDTH-1:0] pixels_flat,
    output logic                   win_valid,
    output logic                   win_last
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic                 col_end;
    logic                 row_end;
    logic                 in_region;

    logic [PIX_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] lb0_rd;
    logic [PIX_WIDTH-1:0] lb1_rd;

    // win[3*ky + kx]: ky=0 oldest row, kx=0 oldest column
    logic [PIX_WIDTH-1:0] win [9];

    assign col_end   = (col == COL_W'(IMG_WIDTH - 1));
    assign row_end   = (row == ROW_W'(IMG_HEIGHT - 1));
    assign in_region = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // Line buffers are read before they are written in the same cycle
    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    // Position of the next pixel to accept; wraps at end of row and frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Push the column down the two-row history (contents are never reset)
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= pix_in;
        end
    end

    // Shift the window left and append the new column {two rows back, previous row, new pixel}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else if (pix_valid) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= pix_in;
        end
    end

    // Strobes are registered alongside the window; stale columns are masked by in_region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= pix_valid && in_region;
            win_last  <= pix_valid && row_end && col_end;
        end
    end

    // Flatten the window registers into the processing-element bus
    always_comb begin
        pixels_flat = '0;
        for (int k = 0; k < 9; k++) begin
            pixels_flat[k*PIX_WIDTH +: PIX_WIDTH] = win[k];
        end
    end

endmodule
